instruction_fetch_unit: RTL

- Consumer end of the next-PC path. Owns the architectural PC and fetches one instruction at a time from instruction memory over a valid/ready request plus response-valid interface.
- Presents Instruction and Instr_PC_Plus4 to decode, so these feed the next-instruction calculator.
- Accepts the calculator's NextInstructionAddress back as a redirect when a jump or taken branch resolves.
- One outstanding memory request at most. Sized for the multicycle MIPS datapath.

---
 rtl/instruction_fetch_unit_pkg.sv | 18 +
 rtl/instruction_fetch_unit_if.sv | 27 ++
 rtl/instruction_fetch_unit.sv | 116 +++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// rtl/instruction_fetch_unit_pkg.sv - shared fetch state encoding, reset PC default and alignment helper.
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_WAIT    = 2'd1,
    S_HOLD    = 2'd2,
    S_DISCARD = 2'd3
  } fetch_state_e;

  // MIPS text segment base
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - imem request/response, decode handoff and redirect signals.
interface instruction_fetch_unit_if;

  logic        ImemReqValid;
  logic        ImemReqReady;
  logic [31:0] ImemAddr;
  logic        ImemRespValid;
  logic [31:0] ImemRespData;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] Instruction;
  logic [31:0] Instr_PC;
  logic [31:0] Instr_PC_Plus4;
  logic        Redirect;
  logic [31:0] RedirectAddress;

  modport master (
    output ImemReqValid, ImemAddr, InstrValid, Instruction, Instr_PC, Instr_PC_Plus4,
    input  ImemReqReady, ImemRespValid, ImemRespData, InstrReady, Redirect, RedirectAddress
  );

  modport slave (
    input  ImemReqValid, ImemAddr, InstrValid, Instruction, Instr_PC, Instr_PC_Plus4,
    output ImemReqReady, ImemRespValid, ImemRespData, InstrReady, Redirect, RedirectAddress
  );

endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - single-outstanding instruction fetch with redirect; FETCH_TRACE_EN adds trace prints.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                     Clock,
  input  logic                     Reset_n,
  instruction_fetch_unit_if.master fetch_bus
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_nxt;
  logic [31:0]  w_pc_plus4;
  logic         r_req_valid;
  logic         r_instr_valid;
  logic         w_instr_valid_nxt;
  logic         w_capture;
  logic         w_req_fire;
  logic         w_resp;
  logic [31:0]  r_instr;
  logic [31:0]  r_instr_pc;
  logic [31:0]  r_instr_pc_plus4;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_req_fire = (r_state == S_REQ) && r_req_valid && fetch_bus.ImemReqReady;
  // Responses only count while a request is actually in flight
  assign w_resp     = ((r_state == S_WAIT) || (r_state == S_DISCARD)) && fetch_bus.ImemRespValid;

  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_instr_valid_nxt = r_instr_valid;
    w_capture         = 1'b0;
    if (fetch_bus.Redirect) begin
      w_pc_nxt          = word_align(fetch_bus.RedirectAddress);
      w_instr_valid_nxt = 1'b0;
      case (r_state)
        S_REQ:             w_state_nxt = w_req_fire ? S_DISCARD : S_REQ;
        S_WAIT, S_DISCARD: w_state_nxt = w_resp ? S_REQ : S_DISCARD;
        default:           w_state_nxt = S_REQ;
      endcase
    end else begin
      case (r_state)
        S_REQ: begin
          if (w_req_fire) w_state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (w_resp) begin
            w_capture         = 1'b1;
            w_pc_nxt          = w_pc_plus4;
            w_instr_valid_nxt = 1'b1;
            w_state_nxt       = S_HOLD;
          end
        end
        S_HOLD: begin
          if (fetch_bus.InstrReady) begin
            w_instr_valid_nxt = 1'b0;
            w_state_nxt       = S_REQ;
          end
        end
        S_DISCARD: begin
          if (w_resp) w_state_nxt = S_REQ;
        end
        default: w_state_nxt = S_REQ;
      endcase
    end
  end

  // Request valid is registered, so it trails entry into REQ by nothing but follows reset by one cycle
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state       <= S_REQ;
      r_pc          <= RESET_PC;
      r_req_valid   <= 1'b0;
      r_instr_valid <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_req_valid   <= (w_state_nxt == S_REQ);
      r_instr_valid <= w_instr_valid_nxt;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_instr          <= 32'd0;
      r_instr_pc       <= 32'd0;
      r_instr_pc_plus4 <= 32'd0;
    end else if (w_capture) begin
      r_instr          <= fetch_bus.ImemRespData;
      r_instr_pc       <= r_pc;
      r_instr_pc_plus4 <= w_pc_plus4;
    end
  end

  assign fetch_bus.ImemReqValid   = r_req_valid;
  assign fetch_bus.ImemAddr       = r_pc;
  assign fetch_bus.InstrValid     = r_instr_valid;
  assign fetch_bus.Instruction    = r_instr;
  assign fetch_bus.Instr_PC       = r_instr_pc;
  assign fetch_bus.Instr_PC_Plus4 = r_instr_pc_plus4;

`ifdef FETCH_TRACE_EN
  always_ff @(posedge Clock) begin
    if (Reset_n && r_instr_valid && fetch_bus.InstrReady)
      $display("Fetch: pc=%x instr=%x", r_instr_pc, r_instr);
    if (Reset_n && fetch_bus.Redirect)
      $display("Redirect: %x -> %x", r_pc, w_pc_nxt);
  end
`else
`endif

endmodule
